mat_key_scan: RTL and testbench
===============================

Name: mat_key_scan

Overview:
Parametrised matrix keypad scanner, the successor to the fixed 4x4 scanner. It drives one-hot active-low row strobes at a programmable dwell rate and samples the active-low columns at the end of each dwell. It debounces whole scan frames and emits a stable key code plus press/release strobes. It sits between the keypad pins and the note-select/control logic of the music player.

Parameters:
ROWS, 4, number of row lines driven (2..8)
COLS, 4, number of column lines sampled (2..8)
SCAN_DIV, 1000, clk cycles per row dwell (>=2)
DEBOUNCE, 4, consecutive identical frames required to commit a press or release (>=1)
KEY_W, $clog2(ROWS*COLS), key code width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (0 = reset)
row  output ROWS  row strobes, active-low, one row low at a time
col  input  COLS  column returns, active-low, externally pulled up
key_code  output KEY_W  committed key index = r*COLS + c
key_valid  output 1  high while a committed key is held
key_press  output 1  one-cycle pulse on press commit
key_release  output 1  one-cycle pulse on release commit
multi  output 1  high for the frame after any frame with >1 key seen

Behaviour:
- Reset (rst low, async): row = all-ones except bit0 low (row 0 selected); dwell counter = 0; row index = 0; key_code = 0; key_valid = 0; key_press = 0; key_release = 0; multi = 0; FSM = IDLE; stable count = 0.
- Dwell counter runs 0..SCAN_DIV-1. On the terminal count, sample col for the current row, then advance the row index (wrap ROWS-1 -> 0). row = ~(1 << index), registered, so only one bit is ever low.
- Sampling happens only on the last dwell cycle, giving SCAN_DIV-1 cycles of settling.
- Per frame (all ROWS sampled), accumulate:
  - hit count, saturating at 2;
  - first hit code = lowest r*COLS + c with col[c]==0 while row r is active.
- Frame result on the frame-end cycle (last sample of row ROWS-1): NONE (0 hits), KEY(k) (1 hit), or MULTI (>=2 hits).
  - multi is registered from the MULTI result and held for one frame.
  - A MULTI frame is treated as "no change": stable count is neither reset nor incremented.
- FSM, evaluated only on frame-end cycles:
  - IDLE: KEY(k) -> latch candidate=k, count=1, go to DB_PRESS (if DEBOUNCE==1, commit immediately).
  - DB_PRESS:
    - KEY(candidate) -> count+1; when count reaches DEBOUNCE, set key_code=candidate and key_valid=1, pulse key_press, go to HELD.
    - KEY(other) -> candidate=other, count=1.
    - NONE -> IDLE.
  - HELD:
    - NONE -> count=1, go to DB_RELEASE.
    - KEY(other) -> ignored; no rollover until release.
  - DB_RELEASE:
    - NONE -> count+1; when count reaches DEBOUNCE, set key_valid=0, pulse key_release, go to IDLE. key_code keeps its last value.
    - KEY(key_code) -> back to HELD.
- Press latency: key_press is asserted the cycle after the frame-end of the DEBOUNCE-th consistent frame.
- key_press and key_release are never asserted in the same cycle.
- A column change mid-dwell has no effect; only the terminal-cycle sample counts.
- Reset asserted mid-frame aborts the frame. The first frame after reset starts at row 0 and its partial data is discarded.

Optional Feature:
Macro KEY_REPEAT_EN.
- Defined: adds parameters REPEAT_DELAY (default 16 frames) and REPEAT_RATE (default 4 frames).
  - In HELD, a frame counter starts at commit. key_press re-pulses after REPEAT_DELAY frames, then every REPEAT_RATE frames, while still HELD.
  - The counter clears on leaving HELD. NONE frames during DB_RELEASE pause repeats.
- Not defined: key_press pulses exactly once per commit and no repeat logic is synthesised.

Test Plan:
All cases use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, so one frame = 16 clk.
1. Reset: hold rst=0 mid-dwell -> row=4'b1110, key_valid=0, all strobes 0. Release -> row steps 1110,1101,1011,0111 every 4 clk and wraps.
2. Clean press: pull col[1] low only while row[2] is low, for 4 frames -> key_press pulse 1 cycle after the 3rd frame-end, key_code=9, key_valid=1.
3. Bounce: key 9 active in frames 1 and 3, absent in frame 2 -> no key_press until 3 consecutive frames are seen.
4. Release: after test 2, remove the key -> key_release pulse after the 3rd empty frame-end, key_valid=0, key_code stays 9.
5. Multi/ghost: keys 0 and 15 pressed together from IDLE -> multi=1 each frame, no key_press. Then release key 15 -> key 0 commits after 3 frames.
6. KEY_REPEAT_EN with REPEAT_DELAY=2, REPEAT_RATE=1: hold key 5 -> key_press at commit, again 2 frames later, then every frame.

Source files
------------

// File: rtl/mat_key_scan.sv
// Matrix keypad scanner: row strobing, frame debounce, press/release strobes.
// Optional auto-repeat of key_press is built when KEY_REPEAT_EN is defined.
module mat_key_scan #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
`ifdef KEY_REPEAT_EN
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
`endif
    parameter int KEY_W    = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROWS-1:0]  row,
    input  logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_press,
    output logic             key_release,
    output logic             multi
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_KEY,
        RES_MULTI
    } res_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [RW-1:0]    idx_q, idx_d;
    logic [ROWS-1:0]  row_q, row_d;
    logic [1:0]       hits_q, hits_d;
    logic [KEY_W-1:0] first_q, first_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             multi_q, multi_d;

    logic             term;
    logic             frame_end;
    logic             cnt_hit;
    res_e             res;
    logic [KEY_W-1:0] res_code;

    // Row strobing and per-frame hit accumulation
    always_comb begin : scan
        int row_hits;
        int low_c;
        int tot;
        row_hits  = 0;
        low_c     = 0;
        term      = (dwell_q == DW'(SCAN_DIV - 1));
        frame_end = term && (idx_q == RW'(ROWS - 1));
        dwell_d   = term ? '0 : dwell_q + DW'(1);
        idx_d     = idx_q;
        if (term) begin
            idx_d = (idx_q == RW'(ROWS - 1)) ? '0 : idx_q + RW'(1);
        end
        row_d = ~(ROWS'(1) << idx_d);

        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col[c]) begin
                row_hits = row_hits + 1;
                low_c    = c;
            end
        end
        tot = int'(hits_q) + row_hits;
        if (tot > 2) begin
            tot = 2;
        end

        if (hits_q == 2'd0 && row_hits > 0) begin
            res_code = KEY_W'(int'(idx_q) * COLS + low_c);
        end else begin
            res_code = first_q;
        end

        if (tot == 0) begin
            res = RES_NONE;
        end else if (tot == 1) begin
            res = RES_KEY;
        end else begin
            res = RES_MULTI;
        end

        hits_d  = hits_q;
        first_d = first_q;
        if (frame_end) begin
            hits_d  = '0;
            first_d = '0;
        end else if (term) begin
            hits_d  = 2'(tot);
            first_d = res_code;
        end
    end

    // Debounce FSM; only frame-end cycles carry a result
    always_comb begin : fsm
        state_d = state_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        multi_d = multi_q;
        cnt_hit = (int'(cnt_q) + 1) >= DEBOUNCE;

        if (frame_end) begin
            multi_d = (res == RES_MULTI);
            unique case (state_q)
                IDLE: begin
                    if (res == RES_KEY) begin
                        cand_d  = res_code;
                        cnt_d   = CW'(1);
                        state_d = DB_PRESS;
                        if (DEBOUNCE == 1) begin
                            code_d  = res_code;
                            valid_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end
                    end
                end
                DB_PRESS: begin
                    if (res == RES_NONE) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (res == RES_KEY) begin
                        if (res_code == cand_q) begin
                            if (cnt_hit) begin
                                code_d  = cand_q;
                                valid_d = 1'b1;
                                press_d = 1'b1;
                                cnt_d   = '0;
                                state_d = HELD;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end else begin
                            cand_d = res_code;
                            cnt_d  = CW'(1);
                        end
                    end
                end
                HELD: begin
                    if (res == RES_NONE) begin
                        cnt_d   = CW'(1);
                        state_d = DB_RELEASE;
                        if (DEBOUNCE == 1) begin
                            valid_d = 1'b0;
                            rel_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
                DB_RELEASE: begin
                    if (res == RES_NONE) begin
                        if (cnt_hit) begin
                            valid_d = 1'b0;
                            rel_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (res == RES_KEY && res_code == code_q) begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dwell_q <= '0;
            idx_q   <= '0;
            row_q   <= ~ROWS'(1);
            hits_q  <= '0;
            first_q <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            hits_q  <= hits_d;
            first_q <= first_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            multi_q <= multi_d;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int PW   = $clog2(RMAX + 1);

    logic [PW-1:0] rep_q, rep_d;
    logic          armed_q, armed_d;
    logic          rep_pulse_q, rep_pulse_d;

    // Repeat frames count only while HELD; DB_RELEASE holds the count
    always_comb begin : repeat_gen
        rep_d       = rep_q;
        armed_d     = armed_q;
        rep_pulse_d = 1'b0;
        if (state_q == IDLE || state_q == DB_PRESS) begin
            rep_d   = '0;
            armed_d = 1'b0;
        end else if (frame_end && state_q == HELD && state_d == HELD) begin
            if ((int'(rep_q) + 1) >= (armed_q ? REPEAT_RATE : REPEAT_DELAY)) begin
                rep_d       = '0;
                armed_d     = 1'b1;
                rep_pulse_d = 1'b1;
            end else begin
                rep_d = rep_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q       <= '0;
            armed_q     <= 1'b0;
            rep_pulse_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            armed_q     <= armed_d;
            rep_pulse_q <= rep_pulse_d;
        end
    end

    assign key_press = press_q | rep_pulse_q;
`else
    assign key_press = press_q;
`endif

    assign row         = row_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_release = rel_q;
    assign multi       = multi_q;

endmodule

// File: tb/tb_mat_key_scan.sv
// Randomised bench for mat_key_scan at 4x4, SCAN_DIV=4, DEBOUNCE=3.
// A frame-level keypad model predicts strobes, key state and multi.
module tb_mat_key_scan;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int KEY_W    = 4;
    localparam int FRAME    = ROWS * SCAN_DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  col;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_press;
    logic             key_release;
    logic             multi;

    logic [15:0] pressed = '0;
    logic [15:0] noise   = '0;
    bit          noise_en = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit m_valid;
    int m_code;
    int m_cand;
    int m_run;
    int m_rel;
    bit m_press;
    bit m_relp;
    bit m_multi;

    always #5 clk = ~clk;

    mat_key_scan #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_press(key_press),
        .key_release(key_release),
        .multi(multi)
    );

    // Passive keypad: a closed switch pulls its column low when its row strobes
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row[r] && (pressed[r*COLS+c] || noise[r*COLS+c])) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] key_bit(input int k);
        return 16'(1) << k;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_code  = 0;
        m_cand  = 0;
        m_run   = 0;
        m_rel   = 0;
        m_press = 1'b0;
        m_relp  = 1'b0;
        m_multi = 1'b0;
    endtask

    // One whole frame with key set s seen by the scanner
    task automatic model_frame(input logic [15:0] s);
        int nh;
        int k;
        nh = $countones(s);
        k  = 0;
        for (int i = 15; i >= 0; i--) begin
            if (s[i]) k = i;
        end
        m_press = 1'b0;
        m_relp  = 1'b0;
        m_multi = (nh >= 2);
        if (nh < 2) begin
            if (!m_valid) begin
                if (nh == 0) begin
                    m_run = 0;
                end else begin
                    if (m_run > 0 && k == m_cand) begin
                        m_run++;
                    end else begin
                        m_cand = k;
                        m_run  = 1;
                    end
                    if (m_run == DEBOUNCE) begin
                        m_valid = 1'b1;
                        m_code  = k;
                        m_press = 1'b1;
                        m_run   = 0;
                        m_rel   = 0;
                    end
                end
            end else begin
                if (nh == 0) begin
                    m_rel++;
                    if (m_rel == DEBOUNCE) begin
                        m_valid = 1'b0;
                        m_relp  = 1'b1;
                        m_rel   = 0;
                    end
                end else if (k == m_code) begin
                    m_rel = 0;
                end
            end
        end
    endtask

    task automatic step();
        logic [3:0] er;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        er = ~(4'b0001 << ((cyc / SCAN_DIV) % ROWS));
        chk("row", row, er);
        if (cyc % FRAME == 0) begin
            chk("press", key_press, m_press);
            chk("release", key_release, m_relp);
            chk("valid", key_valid, m_valid);
            chk("code", key_code, m_code);
            chk("multi", multi, m_multi);
        end else begin
            chk("press_idle", key_press, 0);
            chk("release_idle", key_release, 0);
        end
        // Glitch columns everywhere except the sampling dwell cycle
        if (noise_en && (cyc % SCAN_DIV) != SCAN_DIV - 1) begin
            noise = 16'($urandom);
        end else begin
            noise = '0;
        end
    endtask

    task automatic run_frame(input logic [15:0] m);
        pressed = m;
        model_frame(m);
        repeat (FRAME) step();
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        noise = '0;
        repeat (2) @(negedge clk);
        chk("rst_row", row, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_press", key_press, 0);
        chk("rst_release", key_release, 0);
        chk("rst_multi", multi, 0);
        chk("rst_code", key_code, 0);
        rst = 1'b1;
        cyc = 0;
        model_reset();
    endtask

    initial begin
        logic [15:0] m;
        int          sel;
        model_reset();
        @(negedge clk);
        do_reset();

        repeat (2) run_frame('0);

        repeat (4) run_frame(key_bit(9));
        chk("held_code9", key_code, 9);
        chk("held_valid", key_valid, 1);

        repeat (4) run_frame('0);
        chk("rel_code9", key_code, 9);
        chk("rel_valid", key_valid, 0);

        run_frame(key_bit(9));
        run_frame('0);
        run_frame(key_bit(9));
        run_frame(key_bit(9));
        run_frame(key_bit(9));
        repeat (4) run_frame('0);

        repeat (3) run_frame(key_bit(0) | key_bit(15));
        repeat (4) run_frame(key_bit(0));
        chk("multi_commit_code", key_code, 0);
        repeat (4) run_frame('0);

        repeat (7) step();
        do_reset();

        noise_en = 1'b1;
        for (int f = 0; f < 60; f++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                m = '0;
            end else if (sel < 9) begin
                m = key_bit($urandom_range(0, 15));
            end else begin
                m = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
            end
            repeat ($urandom_range(1, 5)) run_frame(m);
            if (f == 30) begin
                repeat (9) step();
                do_reset();
            end
        end
        noise_en = 1'b0;
        repeat (4) run_frame('0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
